// File: rtl/bist_sweep_ctrl.sv
// bist_sweep_ctrl: exhaustive-sweep BIST controller.
// Drives every input pattern onto a small combinational CUT and waits SETTLE
// cycles per pattern. The CUT response is then folded into a MISR. At the end
// of the sweep the signature is compared against a supplied golden value.
module bist_sweep_ctrl #(
    parameter int                NUM_IN  = 5,
    parameter int                NUM_OUT = 2,
    parameter int                SIG_W   = 16,
    parameter logic [SIG_W-1:0]  POLY    = 16'h1021,
    parameter int                SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [NUM_IN-1:0]  cut_in,
    input  logic [NUM_OUT-1:0] cut_out,
    input  logic [SIG_W-1:0]   golden,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   signature,
    output logic               pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [NUM_IN-1:0] PAT_LAST = '1;
    localparam logic [3:0]        SET_LAST = 4'(SETTLE - 1);

    state_t              state_q;
    logic [NUM_IN-1:0]   pat_q;
    logic [3:0]          set_q;
    logic [SIG_W-1:0]    sig_q;
    logic [SIG_W-1:0]    sig_d;
    logic [SIG_W-1:0]    cut_ext;
    logic                pass_q;
    logic                done_q;
    logic                busy_q;
    logic [NUM_IN-1:0]   cut_in_q;

    // Next MISR value: shift, fold back the polynomial, then mix in the CUT response.
    always_comb begin
        cut_ext                = '0;
        cut_ext[NUM_OUT-1:0]   = cut_out;
        sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ cut_ext;
    end

    // Sweep FSM with all outputs registered; abort wins over every other transition.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            set_q    <= '0;
            sig_q    <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cut_in_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q  <= S_IDLE;
                pat_q    <= '0;
                set_q    <= '0;
                sig_q    <= '0;
                pass_q   <= 1'b0;
                busy_q   <= 1'b0;
                cut_in_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            pat_q    <= '0;
                            set_q    <= '0;
                            sig_q    <= '0;
                            pass_q   <= 1'b0;
                            busy_q   <= 1'b1;
                            cut_in_q <= '0;
                            state_q  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        set_q <= set_q + 4'd1;
                        if (set_q == SET_LAST) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        sig_q <= sig_d;
                        if (pat_q == PAT_LAST) begin
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            cut_in_q <= '0;
                            state_q  <= S_DONE;
                        end else begin
                            pat_q    <= pat_q + 1'b1;
                            cut_in_q <= pat_q + 1'b1;
                            set_q    <= '0;
                            state_q  <= S_WAIT;
                        end
                    end
                    S_DONE: begin
                        pass_q  <= (sig_q == golden);
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cut_in    = cut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_sweep_ctrl.sv
// Directed testbench for bist_sweep_ctrl: default-size instance driving a
// modelled CUT plus a tiny 1-input / 4-bit MISR instance with a tied response.
module tb_bist_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  cut_in;
    logic [1:0]  cut_out;
    logic [15:0] golden;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic        pass;

    logic        cut_sel;
    logic        fault_en;

    logic        start_s;
    logic [0:0]  cut_in_s;
    logic [3:0]  golden_s;
    logic        busy_s;
    logic        done_s;
    logic [3:0]  sig_s;
    logic        pass_s;

    int total;
    int bad;

    bist_sweep_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cut_in    (cut_in),
        .cut_out   (cut_out),
        .golden    (golden),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .pass      (pass)
    );

    bist_sweep_ctrl #(
        .NUM_IN  (1),
        .NUM_OUT (2),
        .SIG_W   (4),
        .POLY    (4'h3),
        .SETTLE  (1)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .abort     (1'b0),
        .cut_in    (cut_in_s),
        .cut_out   (2'b01),
        .golden    (golden_s),
        .busy      (busy_s),
        .done      (done_s),
        .signature (sig_s),
        .pass      (pass_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CUT: bit1 = parity of the inputs, bit0 = (x0 & x1) | x4.
    function automatic logic [1:0] cut_fn(input logic [4:0] x);
        return {^x, (x[0] & x[1]) | x[4]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] o);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, o};
    endfunction

    // Response seen by the DUT; the planted fault flips bit0 while pattern 7 is applied.
    always_comb begin
        cut_out = cut_sel ? cut_fn(cut_in) : 2'b00;
        if (fault_en && cut_in == 5'd7) cut_out = cut_out ^ 2'b01;
    end

    task automatic model_signature(input bit faulty, output logic [15:0] g);
        logic [1:0] o;
        g = 16'h0000;
        for (int p = 0; p < 32; p++) begin
            o = cut_fn(5'(p));
            if (faulty && p == 7) o = o ^ 2'b01;
            g = misr_step(g, o);
        end
    endtask

    // Pulse start across one rising edge (t0); returns at the negedge after t0.
    task automatic start_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; cycles = negedges waited, or -1 on timeout.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (done !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || cut_in !== 5'd0 || signature !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b cut_in=%0d sig=%h, required all zero",
                     busy, done, pass, cut_in, signature);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_zero_sweep();
        int errs;
        cut_sel = 1'b0;
        golden  = 16'h0000;
        start_sweep();
        errs = 0;
        for (int k = 0; k < 64; k++) begin
            if (cut_in !== 5'(k >> 1) || busy !== 1'b1 || done !== 1'b0) begin
                errs++;
                if (errs < 4)
                    $display("FAIL zero_sweep_step k=%0d: cut_in=%0d busy=%b done=%b, required cut_in=%0d busy=1 done=0",
                             k, cut_in, busy, done, k >> 1);
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL zero_sweep_walk: %0d bad cycles, required 0", errs);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || cut_in !== 5'd0 || signature !== 16'h0000) begin
            bad++;
            $display("FAIL zero_sweep_done: done=%b busy=%b cut_in=%0d sig=%h, required 1 0 0 0000",
                     done, busy, cut_in, signature);
        end
        @(negedge clk);
        total++;
        if (pass !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL zero_sweep_pass: pass=%b done=%b, required pass=1 done=0", pass, done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (pass !== 1'b1 || signature !== 16'h0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_sweep_hold: pass=%b sig=%h busy=%b, required 1 0000 0", pass, signature, busy);
        end
    endtask

    task automatic test_small_misr(input logic [3:0] gold, input logic exp_pass);
        golden_s = gold;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        total++;
        if (pass_s !== 1'b0 || busy_s !== 1'b1 || cut_in_s !== 1'b0) begin
            bad++;
            $display("FAIL small_start: pass=%b busy=%b cut_in=%b, required 0 1 0", pass_s, busy_s, cut_in_s);
        end
        repeat (2) @(negedge clk);
        total++;
        if (sig_s !== 4'h1 || cut_in_s !== 1'b1) begin
            bad++;
            $display("FAIL small_first_capture: sig=%h cut_in=%b, required 1 1", sig_s, cut_in_s);
        end
        repeat (2) @(negedge clk);
        total++;
        if (sig_s !== 4'h3 || done_s !== 1'b1) begin
            bad++;
            $display("FAIL small_second_capture: sig=%h done=%b, required 3 1", sig_s, done_s);
        end
        @(negedge clk);
        total++;
        if (pass_s !== exp_pass) begin
            bad++;
            $display("FAIL small_pass golden=%h: pass=%b, required %b", gold, pass_s, exp_pass);
        end
    endtask

    task automatic test_cut_golden(input bit faulty);
        logic [15:0] g_good;
        logic [15:0] g_seen;
        int cycles;
        model_signature(1'b0, g_good);
        model_signature(faulty, g_seen);
        cut_sel  = 1'b1;
        fault_en = faulty;
        golden   = g_good;
        start_sweep();
        wait_done(cycles);
        total++;
        if (cycles != 64) begin
            bad++;
            $display("FAIL cut_done_latency faulty=%0d: %0d cycles, required 64", faulty, cycles);
        end
        total++;
        if (signature !== g_seen) begin
            bad++;
            $display("FAIL cut_signature faulty=%0d: sig=%h, required %h", faulty, signature, g_seen);
        end
        @(negedge clk);
        total++;
        if (pass !== !faulty) begin
            bad++;
            $display("FAIL cut_pass faulty=%0d: pass=%b, required %b", faulty, pass, !faulty);
        end
        fault_en = 1'b0;
    endtask

    task automatic test_abort();
        int cycles;
        int done_seen;
        cut_sel = 1'b1;
        start_sweep();
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || cut_in !== 5'd0 || signature !== 16'h0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL abort_clear: busy=%b cut_in=%0d sig=%h pass=%b, required 0 0 0000 0",
                     busy, cut_in, signature, pass);
        end
        done_seen = 0;
        for (int k = 0; k < 70; k++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", done_seen);
        end
        // abort outranks start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_priority: busy=%b, required 0", busy);
        end
        start_sweep();
        wait_done(cycles);
        total++;
        if (cycles != 64) begin
            bad++;
            $display("FAIL abort_resweep: %0d cycles, required 64", cycles);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cycles;
        cut_sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        repeat (30) @(negedge clk);
        total++;
        if (cut_in !== 5'd15 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_mid: cut_in=%0d busy=%b, required 15 1", cut_in, busy);
        end
        cycles = 30;
        while (done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        total++;
        if (cycles != 64) begin
            bad++;
            $display("FAIL b2b_first_done: %0d cycles, required 64", cycles);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || cut_in !== 5'd0) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b cut_in=%0d, required 1 0", busy, cut_in);
        end
        wait_done(cycles);
        total++;
        if (cycles != 64) begin
            bad++;
            $display("FAIL b2b_second_done: %0d cycles, required 64", cycles);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int stray;
        cut_sel = 1'b1;
        start_sweep();
        repeat (24) @(negedge clk);
        total++;
        if (cut_in !== 5'd12 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_setup: cut_in=%0d busy=%b, required 12 1", cut_in, busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || cut_in !== 5'd0 || signature !== 16'h0) begin
            bad++;
            $display("FAIL rst_async: busy=%b done=%b pass=%b cut_in=%0d sig=%h, required all zero",
                     busy, done, pass, cut_in, signature);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || cut_in !== 5'd0 || done !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rst_stays_idle: %0d active cycles, required 0", stray);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total    = 0;
        bad      = 0;
        start    = 1'b0;
        abort    = 1'b0;
        golden   = 16'h0;
        cut_sel  = 1'b0;
        fault_en = 1'b0;
        start_s  = 1'b0;
        golden_s = 4'h0;
        test_reset();
        test_zero_sweep();
        test_small_misr(4'h3, 1'b1);
        test_small_misr(4'h2, 1'b0);
        test_cut_golden(1'b0);
        test_cut_golden(1'b1);
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist_sweep_ctrl.md
# bist_sweep_ctrl

Exhaustive-sweep BIST controller for the small combinational benchmark netlists in this codebase (5-input / 2-output class). On `start` it drives every input pattern 0 … 2^NUM_IN−1 onto the circuit under test (CUT) and waits a programmable settle time. It then captures the CUT outputs into a multiple-input signature register (MISR) and, at the end of the sweep, compares the signature against a supplied golden value. It sits beside the CUT instance in the test harness and replaces the testbench-driven stimulus.

## Interface
Parameters:
- NUM_IN, 5, CUT input count; pattern counter width.
- NUM_OUT, 2, CUT output count; must be ≤ SIG_W.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SETTLE, 1, settle cycles per pattern; legal range 1 … 15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  cancel sweep; returns to IDLE.
- cut_in  out  NUM_IN  pattern driven to CUT inputs.
- cut_out  in  NUM_OUT  CUT outputs.
- golden  in  SIG_W  expected final signature; must be stable while in DONE.
- busy  out  1  high in WAIT or CAPTURE.
- done  out  1  one-cycle pulse at sweep completion.
- signature  out  SIG_W  MISR contents.
- pass  out  1  registered result of (signature == golden).

## Operation
- FSM states: IDLE, WAIT, CAPTURE, DONE.
- IDLE:
  - start=1 and abort=0 → pat←0, sig←0, pass←0, set←0, go to WAIT.
  - abort has priority over start.
- WAIT:
  - cut_in=pat; set increments each cycle.
  - After SETTLE cycles in WAIT → CAPTURE.
- CAPTURE: single cycle. At its closing edge:
  - sig ← {sig[SIG_W−2:0],1'b0} ^ (sig[SIG_W−1] ? POLY : 0) ^ zero_ext(cut_out).
  - If pat == 2^NUM_IN−1 → DONE; else pat←pat+1, set←0, go to WAIT.
  - The pattern counter never wraps during a sweep.
- DONE: single cycle.
  - done=1.
  - At its closing edge: pass ← (sig == golden); return to IDLE.
- signature and pass hold their values in IDLE until the next accepted start.
- abort=1 in WAIT, CAPTURE or DONE:
  - Next state IDLE; done not pulsed.
  - sig←0, pass←0, cut_in←0.
  - An abort in CAPTURE suppresses that cycle's MISR update.
- start while busy or in DONE: ignored.
- cut_in=0 in IDLE and DONE.
- Async rst (any time, including mid-sweep):
  - State IDLE; cut_in=0, signature=0, pass=0, done=0, busy=0, internal counters 0.
  - Outputs go low without waiting for a clock edge.

## Timing
- start accepted at edge t0. cut_in=0 valid from t0; busy=1 from t0.
- Each pattern occupies SETTLE+1 cycles (SETTLE in WAIT, 1 in CAPTURE).
- CUT outputs are sampled at the end of the CAPTURE cycle, i.e. SETTLE+1 cycles after the pattern is applied.
- DONE is entered at edge t0 + 2^NUM_IN·(SETTLE+1).
  - Defaults: t0+64. busy falls and done=1 for that cycle.
- pass is valid from edge t0 + 2^NUM_IN·(SETTLE+1) + 1 onward; IDLE at the same edge.
- A new start is accepted on the first IDLE cycle after DONE.
- All outputs are registered; no combinational path from cut_out, golden, start or abort to any output.

## Test plan
- Default params, cut_out tied 2'b00, golden=16'h0000, start at t0:
  - cut_in steps 0…31, each value held 2 cycles.
  - done pulses in the cycle after edge t0+64; signature=16'h0000; pass=1 one edge later.
- NUM_IN=1, SIG_W=4, POLY=4'h3, SETTLE=1, cut_out tied 2'b01, golden=4'h3:
  - signature 4'h1 after first capture, 4'h3 after second; pass=1.
  - Repeat with golden=4'h2 → pass=0.
- Default params, CUT = test_08 netlist, golden from the software model of that netlist → pass=1.
  - Force one cut_out bit for one capture → pass=0.
- abort asserted at cycle t0+20:
  - Next edge: busy=0, cut_in=0, signature=0; done never pulses.
  - Subsequent start runs a full 64-cycle sweep.
- start held high continuously from t0:
  - Sweeps run back-to-back. The first DONE is followed by IDLE for one cycle, then a new sweep; no start is accepted mid-sweep.
- rst pulsed asynchronously (between clock edges) mid-WAIT at pattern 12:
  - All outputs go to reset values immediately.
  - After release, the FSM stays IDLE until start.
